pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the multi-cycle/pipelined datapath; replaces the fixed per-stage latch registers between IF/ID/EX/MEM/WB. Carries a control field and a data field, and adds a valid/ready handshake, back-pressure (stall), synchronous flush (bubble insertion) and an optional 2-entry skid buffer that registers the upstream ready path. One instance sits between each adjacent pair of pipeline stages.

---
 rtl/pipe_stage_reg.sv | 176 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying a control and a data field between two stages,
// with valid/ready handshake, stall, synchronous flush and an optional 2-entry skid buffer.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int SKID   = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CTRL_W-1:0] CTRL_ZERO = {CTRL_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [1:0]        held;
  logic              ready;

  generate
    if (SKID == 0) begin : g_single
      logic accept;
      logic release_beat;

      // Ready passes straight through: free when empty or when the head leaves now.
      always_comb begin
        ready        = !main_valid || out_ready;
        accept       = in_valid && ready;
        release_beat = main_valid && out_ready;
      end

      // Single main register; ctrl is kept at zero whenever the entry is invalid.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          main_valid <= 1'b0;
          main_ctrl  <= CTRL_ZERO;
          main_data  <= DATA_ZERO;
        end else if (Flush) begin
          main_valid <= 1'b0;
          main_ctrl  <= CTRL_ZERO;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_ctrl  <= in_ctrl;
          main_data  <= in_data;
        end else if (release_beat) begin
          main_valid <= 1'b0;
          main_ctrl  <= CTRL_ZERO;
        end else begin
          main_valid <= main_valid;
        end
      end

      always_comb begin
        held = {1'b0, main_valid};
      end
    end else begin : g_skid
      state_t            state;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;
      logic              ready_r;
      logic [1:0]        count_r;
      logic              accept;
      logic              release_beat;

      // in_ready comes from a flop, so out_ready never reaches it combinationally.
      always_comb begin
        ready        = ready_r;
        accept       = in_valid && ready_r;
        release_beat = main_valid && out_ready;
        held         = count_r;
      end

      // EMPTY/ONE/FULL controller; the skid entry absorbs the one beat in flight when
      // out_ready drops, and refills the head once the stall clears.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          state      <= ST_EMPTY;
          main_valid <= 1'b0;
          main_ctrl  <= CTRL_ZERO;
          main_data  <= DATA_ZERO;
          skid_ctrl  <= CTRL_ZERO;
          skid_data  <= DATA_ZERO;
          ready_r    <= 1'b1;
          count_r    <= 2'd0;
        end else if (Flush) begin
          state      <= ST_EMPTY;
          main_valid <= 1'b0;
          main_ctrl  <= CTRL_ZERO;
          skid_ctrl  <= CTRL_ZERO;
          ready_r    <= 1'b1;
          count_r    <= 2'd0;
        end else begin
          case (state)
            ST_EMPTY: begin
              if (accept) begin
                state      <= ST_ONE;
                main_valid <= 1'b1;
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
                count_r    <= 2'd1;
              end else begin
                state <= ST_EMPTY;
              end
            end
            ST_ONE: begin
              if (accept && release_beat) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
              end else if (accept) begin
                state     <= ST_FULL;
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
                ready_r   <= 1'b0;
                count_r   <= 2'd2;
              end else if (release_beat) begin
                state      <= ST_EMPTY;
                main_valid <= 1'b0;
                main_ctrl  <= CTRL_ZERO;
                count_r    <= 2'd0;
              end else begin
                state <= ST_ONE;
              end
            end
            ST_FULL: begin
              if (release_beat) begin
                state     <= ST_ONE;
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
                skid_ctrl <= CTRL_ZERO;
                ready_r   <= 1'b1;
                count_r   <= 2'd1;
              end else begin
                state <= ST_FULL;
              end
            end
            default: begin
              state      <= ST_EMPTY;
              main_valid <= 1'b0;
              main_ctrl  <= CTRL_ZERO;
              skid_ctrl  <= CTRL_ZERO;
              ready_r    <= 1'b1;
              count_r    <= 2'd0;
            end
          endcase
        end
      end
    end
  endgenerate

  // Bubbles never present a live control field downstream.
  always_comb begin
    in_ready  = ready;
    out_valid = main_valid;
    out_ctrl  = main_valid ? main_ctrl : CTRL_ZERO;
    out_data  = main_data;
    count     = held;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance driven in turn.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  int          total = 0;
  int          bad = 0;

  // SKID=0 instance signals
  logic        r0 = 1'b0, f0 = 1'b0, iv0 = 1'b0, or0 = 1'b0;
  logic [1:0]  ic0 = 2'd0;
  logic [31:0] id0 = 32'd0;
  logic        ir0, ov0;
  logic [1:0]  oc0, cnt0;
  logic [31:0] od0;

  // SKID=1 instance signals
  logic        r1 = 1'b0, f1 = 1'b0, iv1 = 1'b0, or1 = 1'b0;
  logic [1:0]  ic1 = 2'd0;
  logic [31:0] id1 = 32'd0;
  logic        ir1, ov1;
  logic [1:0]  oc1, cnt1;
  logic [31:0] od1;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .SKID(0)) u_single (
    .Clk(clk), .Reset(r0), .Flush(f0),
    .in_valid(iv0), .in_ready(ir0), .in_ctrl(ic0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_ctrl(oc0), .out_data(od0), .count(cnt0)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .SKID(1)) u_skid (
    .Clk(clk), .Reset(r1), .Flush(f1),
    .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_ctrl(oc1), .out_data(od1), .count(cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic v, input logic [1:0] c,
                      input logic [31:0] d, input logic [1:0] n, input logic r);
    chk({tag, "_valid"}, {31'd0, ov0}, {31'd0, v});
    chk({tag, "_ctrl"},  {30'd0, oc0}, {30'd0, c});
    chk({tag, "_data"},  od0, d);
    chk({tag, "_count"}, {30'd0, cnt0}, {30'd0, n});
    chk({tag, "_ready"}, {31'd0, ir0}, {31'd0, r});
  endtask

  task automatic chk1(input string tag, input logic v, input logic [1:0] c,
                      input logic [31:0] d, input logic [1:0] n, input logic r);
    chk({tag, "_valid"}, {31'd0, ov1}, {31'd0, v});
    chk({tag, "_ctrl"},  {30'd0, oc1}, {30'd0, c});
    chk({tag, "_data"},  od1, d);
    chk({tag, "_count"}, {30'd0, cnt1}, {30'd0, n});
    chk({tag, "_ready"}, {31'd0, ir1}, {31'd0, r});
  endtask

  initial begin
    logic [31:0] v;

    // ---------------- SKID=0 ----------------
    r0 = 1'b1; tick(); r0 = 1'b0;
    chk0("s0_reset", 1'b0, 2'd0, 32'd0, 2'd0, 1'b1);

    or0 = 1'b1; iv0 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      v = i;
      id0 = v; ic0 = v[1:0];
      tick();
      chk0("s0_stream", 1'b1, v[1:0], v, 2'd1, 1'b1);
    end

    id0 = 32'hA5; ic0 = 2'b10; tick();
    chk0("s0_head", 1'b1, 2'b10, 32'hA5, 2'd1, 1'b1);
    or0 = 1'b0; id0 = 32'hB6; ic0 = 2'b01; #1;
    chk("s0_stall_ready_now", {31'd0, ir0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk0("s0_stall", 1'b1, 2'b10, 32'hA5, 2'd1, 1'b0);
    end
    or0 = 1'b1; #1;
    chk("s0_unstall_ready", {31'd0, ir0}, 32'd1);
    tick();
    chk0("s0_after_stall", 1'b1, 2'b01, 32'hB6, 2'd1, 1'b1);

    iv0 = 1'b0; ic0 = 2'b11; id0 = 32'hCC; tick();
    chk0("s0_bubble1", 1'b0, 2'd0, 32'hB6, 2'd0, 1'b1);
    tick();
    chk0("s0_bubble2", 1'b0, 2'd0, 32'hB6, 2'd0, 1'b1);

    iv0 = 1'b1; id0 = 32'h11; ic0 = 2'b11; tick();
    chk0("s0_load", 1'b1, 2'b11, 32'h11, 2'd1, 1'b1);
    f0 = 1'b1; or0 = 1'b0; id0 = 32'h55; tick();
    chk0("s0_flush", 1'b0, 2'd0, 32'h11, 2'd0, 1'b1);
    f0 = 1'b0; iv0 = 1'b0; tick();
    chk0("s0_post_flush", 1'b0, 2'd0, 32'h11, 2'd0, 1'b1);

    // ---------------- SKID=1 ----------------
    r1 = 1'b1; tick(); r1 = 1'b0;
    chk1("s1_reset", 1'b0, 2'd0, 32'd0, 2'd0, 1'b1);

    or1 = 1'b1; iv1 = 1'b1;
    id1 = 32'd1; ic1 = 2'b01; tick();
    chk1("s1_b1", 1'b1, 2'b01, 32'd1, 2'd1, 1'b1);
    id1 = 32'd2; ic1 = 2'b10; tick();
    chk1("s1_b2", 1'b1, 2'b10, 32'd2, 2'd1, 1'b1);
    or1 = 1'b0; id1 = 32'd3; ic1 = 2'b11; #1;
    chk("s1_ready_registered", {31'd0, ir1}, 32'd1);
    tick();
    chk1("s1_absorb", 1'b1, 2'b10, 32'd2, 2'd2, 1'b0);
    id1 = 32'd4; ic1 = 2'b00; tick();
    chk1("s1_hold", 1'b1, 2'b10, 32'd2, 2'd2, 1'b0);
    or1 = 1'b1; #1;
    chk("s1_ready_still_low", {31'd0, ir1}, 32'd0);
    tick();
    chk1("s1_drain_skid", 1'b1, 2'b11, 32'd3, 2'd1, 1'b1);
    tick();
    chk1("s1_b4", 1'b1, 2'b00, 32'd4, 2'd1, 1'b1);
    id1 = 32'd5; ic1 = 2'b01; tick();
    chk1("s1_b5", 1'b1, 2'b01, 32'd5, 2'd1, 1'b1);
    iv1 = 1'b0; ic1 = 2'b11; tick();
    chk1("s1_empty", 1'b0, 2'd0, 32'd5, 2'd0, 1'b1);

    // Flush from FULL with an upstream beat offered
    or1 = 1'b0; iv1 = 1'b1; ic1 = 2'b11; id1 = 32'h21; tick();
    id1 = 32'h22; tick();
    chk1("s1_full", 1'b1, 2'b11, 32'h21, 2'd2, 1'b0);
    f1 = 1'b1; id1 = 32'h77; tick();
    chk1("s1_flush_full", 1'b0, 2'd0, 32'h21, 2'd0, 1'b1);
    f1 = 1'b0; iv1 = 1'b0; or1 = 1'b1; tick();
    chk1("s1_flush_nodrop", 1'b0, 2'd0, 32'h21, 2'd0, 1'b1);

    // Flush in ONE drops the beat accepted in the same cycle
    or1 = 1'b0; iv1 = 1'b1; ic1 = 2'b01; id1 = 32'h31; tick();
    chk1("s1_one", 1'b1, 2'b01, 32'h31, 2'd1, 1'b1);
    f1 = 1'b1; id1 = 32'h77; tick();
    chk1("s1_flush_one", 1'b0, 2'd0, 32'h31, 2'd0, 1'b1);
    f1 = 1'b0; iv1 = 1'b0; or1 = 1'b1; tick();
    chk1("s1_flush_one_after", 1'b0, 2'd0, 32'h31, 2'd0, 1'b1);

    // Reset beats Flush and accept
    or1 = 1'b0; iv1 = 1'b1; ic1 = 2'b11; id1 = 32'h41; tick();
    id1 = 32'h42; tick();
    chk1("s1_full2", 1'b1, 2'b11, 32'h41, 2'd2, 1'b0);
    r1 = 1'b1; f1 = 1'b1; id1 = 32'h99; tick();
    chk1("s1_reset_mid", 1'b0, 2'd0, 32'd0, 2'd0, 1'b1);
    r1 = 1'b0; f1 = 1'b0; iv1 = 1'b0; tick();
    chk1("s1_reset_after", 1'b0, 2'd0, 32'd0, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
